mem_port_arbiter: RTL and testbench

- Arbitrates the single external memory port (the mem_* interface of axi_interface) between two requesters: instruction-cache refill and the data path (D-cache refill/writeback or uncached load/store).
- Replaces the combinational inst_miss select in the CPU top with a registered grant FSM.
- Data is prioritised, with a bounded-starvation guarantee for instruction fetch and exception-flush cancellation of data transactions.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Registered grant arbiter for the single external memory port, shared by
// instruction refill and the data path, with bounded fetch starvation.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  input  logic        flush,
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_a,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic        mem_flush,
  output logic        grant_i,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic [2:0] CNT_MAX = 3'(STARVE_MAX);

  state_t     state;
  logic [2:0] starve_cnt;
  logic       starved;
  logic       take_d;

  // Data wins unless fetch has already waited out CNT_MAX data grants.
  assign starved = i_req && (starve_cnt == CNT_MAX);
  assign take_d  = d_req && !flush && !starved;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (take_d) begin
            state <= GNT_D;
            if (i_req && (starve_cnt < CNT_MAX)) starve_cnt <= starve_cnt + 3'd1;
          end else if (i_req) begin
            state      <= GNT_I;
            starve_cnt <= 3'd0;
          end
        end
        GNT_I: begin
          if (mem_ready) state <= IDLE;
        end
        GNT_D: begin
          if (mem_ready || flush) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; everything is forced low during reset.
  always_comb begin
    mem_access  = 1'b0;
    mem_write   = 1'b0;
    mem_size    = 2'b00;
    mem_sel     = 4'b0000;
    mem_a       = 32'd0;
    mem_st_data = 32'd0;
    i_ready     = 1'b0;
    d_ready     = 1'b0;
    i_rdata     = 32'd0;
    d_rdata     = 32'd0;
    mem_flush   = 1'b0;
    grant_i     = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      i_rdata = mem_data;
      d_rdata = mem_data;
      case (state)
        GNT_I: begin
          mem_access = 1'b1;
          mem_a      = i_addr;
          mem_size   = 2'b10;
          mem_sel    = 4'b1111;
          grant_i    = 1'b1;
          busy       = 1'b1;
          i_ready    = mem_ready;
        end
        GNT_D: begin
          mem_access  = 1'b1;
          mem_a       = d_addr;
          mem_write   = d_wr;
          mem_size    = d_size;
          mem_sel     = d_sel;
          mem_st_data = d_wdata;
          busy        = 1'b1;
          mem_flush   = flush;
          d_ready     = mem_ready && !flush;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, a starvation
// ordering sequence, and randomized traffic against a behavioural model.
module tb_mem_port_arbiter;

  localparam int SM = 4;

  typedef struct packed {
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        flush;
    logic        mem_ready;
    logic [31:0] mem_data;
  } in_t;

  typedef struct packed {
    logic        access;
    logic        write;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] st;
    logic        iry;
    logic        dry;
    logic [31:0] ird;
    logic [31:0] drd;
    logic        mflush;
    logic        gi;
    logic        busy;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, i_req, i_ready, d_req, d_wr, d_ready, flush;
  logic        mem_access, mem_write, mem_ready, mem_flush, grant_i, busy;
  logic [1:0]  d_size, mem_size;
  logic [3:0]  d_sel, mem_sel;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_a, mem_st_data, mem_data;

  mem_port_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_sel(d_sel),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .flush(flush),
    .mem_access(mem_access), .mem_write(mem_write), .mem_size(mem_size),
    .mem_sel(mem_sel), .mem_a(mem_a), .mem_st_data(mem_st_data),
    .mem_ready(mem_ready), .mem_data(mem_data), .mem_flush(mem_flush),
    .grant_i(grant_i), .busy(busy)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  in_t  cur;
  vec_t tbl[$];

  // Behavioural model: who owns the port, and how many data grants in a row
  // have been handed out while fetch was waiting.
  localparam int OWN_NONE = 0, OWN_INST = 1, OWN_DATA = 2;
  int m_owner  = OWN_NONE;
  int m_streak = 0;

  function automatic out_t model_expect();
    out_t e = '0;
    if (cur.rst) return e;
    e.ird = cur.mem_data;
    e.drd = cur.mem_data;
    if (m_owner == OWN_INST) begin
      e.access = 1'b1; e.a = cur.i_addr; e.size = 2'd2; e.sel = 4'hF;
      e.gi = 1'b1; e.busy = 1'b1; e.iry = cur.mem_ready;
    end else if (m_owner == OWN_DATA) begin
      e.access = 1'b1; e.a = cur.d_addr; e.write = cur.d_wr; e.size = cur.d_size;
      e.sel = cur.d_sel; e.st = cur.d_wdata; e.busy = 1'b1;
      e.mflush = cur.flush; e.dry = cur.mem_ready & ~cur.flush;
    end
    return e;
  endfunction

  task automatic model_update();
    if (cur.rst) begin
      m_owner  = OWN_NONE;
      m_streak = 0;
    end else if (m_owner == OWN_NONE) begin
      if (cur.d_req && !cur.flush && !(cur.i_req && m_streak == SM)) begin
        m_owner = OWN_DATA;
        if (cur.i_req && m_streak < SM) m_streak++;
      end else if (cur.i_req) begin
        m_owner  = OWN_INST;
        m_streak = 0;
      end
    end else if (m_owner == OWN_INST) begin
      if (cur.mem_ready) m_owner = OWN_NONE;
    end else begin
      if (cur.mem_ready || cur.flush) m_owner = OWN_NONE;
    end
  endtask

  function automatic out_t sample();
    out_t s;
    s.access = mem_access; s.write = mem_write; s.size = mem_size; s.sel = mem_sel;
    s.a = mem_a; s.st = mem_st_data; s.iry = i_ready; s.dry = d_ready;
    s.ird = i_rdata; s.drd = d_rdata; s.mflush = mem_flush; s.gi = grant_i; s.busy = busy;
    return s;
  endfunction

  function automatic out_t o_idle(in_t x);
    out_t e = '0;
    e.ird = x.mem_data;
    e.drd = x.mem_data;
    return e;
  endfunction

  function automatic out_t o_gi(in_t x, logic iry);
    out_t e = o_idle(x);
    e.access = 1'b1; e.a = x.i_addr; e.size = 2'd2; e.sel = 4'hF;
    e.gi = 1'b1; e.busy = 1'b1; e.iry = iry;
    return e;
  endfunction

  function automatic out_t o_gd(in_t x, logic dry, logic mflush);
    out_t e = o_idle(x);
    e.access = 1'b1; e.a = x.d_addr; e.write = x.d_wr; e.size = x.d_size;
    e.sel = x.d_sel; e.st = x.d_wdata; e.busy = 1'b1; e.dry = dry; e.mflush = mflush;
    return e;
  endfunction

  task automatic add(in_t x, out_t e);
    vec_t r;
    r.stim = x;
    r.exp  = e;
    tbl.push_back(r);
  endtask

  task automatic apply_stimulus(in_t x);
    cur       = x;
    rst       = x.rst;       i_req   = x.i_req;   i_addr  = x.i_addr;
    d_req     = x.d_req;     d_wr    = x.d_wr;    d_size  = x.d_size;
    d_sel     = x.d_sel;     d_addr  = x.d_addr;  d_wdata = x.d_wdata;
    flush     = x.flush;     mem_ready = x.mem_ready; mem_data = x.mem_data;
  endtask

  task automatic check_output(string name, out_t act, out_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One cycle: drive at the falling edge, check just after, then let the
  // model see the same inputs at the rising edge.
  task automatic run_cycle(in_t x, out_t exp, bit use_model, string name);
    apply_stimulus(x);
    #1;
    if (use_model) exp = model_expect();
    check_output(name, sample(), exp);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    in_t   v;
    out_t  dummy = '0;
    string order = "";
    int    budget;

    apply_stimulus('{rst: 1'b1, default: '0});

    // Directed vector table.
    v = '0; v.rst = 1; add(v, '0);
    v.i_req = 1; v.mem_ready = 1; add(v, '0);
    v = '0; v.i_req = 1; v.i_addr = 32'hBFC00000; add(v, o_idle(v));
    add(v, o_gi(v, 0));
    add(v, o_gi(v, 0));
    v.mem_ready = 1; v.mem_data = 32'h24010001; add(v, o_gi(v, 1));
    v = '0; add(v, o_idle(v));
    v.i_req = 1; v.i_addr = 32'hBFC00004; v.d_req = 1; v.d_wr = 1; v.d_size = 2'd1;
    v.d_sel = 4'b0011; v.d_addr = 32'hBFAF8000; v.d_wdata = 32'h1234; add(v, o_idle(v));
    add(v, o_gd(v, 0, 0));
    v.mem_ready = 1; v.mem_data = 32'hCAFEF00D; add(v, o_gd(v, 1, 0));
    v.d_req = 0; v.mem_ready = 0; v.mem_data = 0; add(v, o_idle(v));
    add(v, o_gi(v, 0));
    v.mem_ready = 1; v.mem_data = 32'h8C220000; add(v, o_gi(v, 1));
    v = '0; v.d_req = 1; v.d_size = 2'd2; v.d_sel = 4'hF; v.d_addr = 32'hBFAF8010; add(v, o_idle(v));
    v.i_req = 1; v.i_addr = 32'hBFC00008; v.flush = 1; add(v, o_gd(v, 0, 1));
    v.d_req = 0; v.flush = 0; add(v, o_idle(v));
    add(v, o_gi(v, 0));
    v.mem_ready = 1; v.mem_data = 32'h3C1D0000; add(v, o_gi(v, 1));
    v = '0; v.d_req = 1; v.d_wr = 1; v.d_size = 2'd0; v.d_sel = 4'b0001;
    v.d_addr = 32'hBFAF8020; v.d_wdata = 32'hAB; add(v, o_idle(v));
    v.flush = 1; v.mem_ready = 1; v.mem_data = 32'h55; add(v, o_gd(v, 0, 1));
    v = '0; add(v, o_idle(v));
    v.d_req = 1; v.flush = 1; v.d_size = 2'd2; v.d_sel = 4'hF; v.d_addr = 32'hBFAF8030; add(v, o_idle(v));
    v.flush = 0; add(v, o_idle(v));
    v.mem_ready = 1; v.mem_data = 32'h11223344; add(v, o_gd(v, 1, 0));
    v = '0; v.i_req = 1; v.i_addr = 32'hBFC00010; add(v, o_idle(v));
    v.flush = 1; add(v, o_gi(v, 0));
    v.flush = 0; v.rst = 1; v.mem_ready = 1; v.mem_data = 32'hDEADBEEF; add(v, '0);
    v = '0; add(v, o_idle(v));

    @(negedge clk);
    foreach (tbl[k]) run_cycle(tbl[k].stim, tbl[k].exp, 1'b0, $sformatf("vec%0d", k));

    // Starvation: both requesters always pending, every grant completes at once.
    v = '0; v.i_req = 1; v.i_addr = 32'hBFC00020; v.d_req = 1; v.d_size = 2'd2;
    v.d_sel = 4'hF; v.d_addr = 32'hBFAF8040;
    budget = 0;
    while (order.len() < 6 && budget < 40) begin
      v.mem_ready = mem_access;
      v.mem_data  = $urandom;
      if (mem_access) order = {order, grant_i ? "I" : "D"};
      run_cycle(v, dummy, 1'b1, "starve_cycle");
      budget++;
    end
    n_checks++;
    if (order == "DDDDID") n_pass++;
    else $display("[TB] FAIL starve_order: got %s, expected DDDDID", order);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      v           = '0;
      v.rst       = ($urandom_range(0, 49) == 0);
      v.i_req     = ($urandom_range(0, 3) != 0);
      v.i_addr    = $urandom;
      v.d_req     = ($urandom_range(0, 3) != 0);
      v.d_wr      = 1'($urandom_range(0, 1));
      v.d_size    = 2'($urandom_range(0, 2));
      v.d_sel     = 4'($urandom);
      v.d_addr    = $urandom;
      v.d_wdata   = $urandom;
      v.flush     = ($urandom_range(0, 7) == 0);
      v.mem_ready = ($urandom_range(0, 2) == 0);
      v.mem_data  = $urandom;
      run_cycle(v, dummy, 1'b1, $sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
